pc_redirect_controller: RTL and testbench
=========================================

Name: pc_redirect_controller

Overview:
- Owns the program counter and selects the next PC for the fetch stage from three sources: sequential PC+4, branch target (BTA, resolved in EX), and jump target (formed in ID).
- Applies stall from the hazard unit, raises pipeline flush strobes on redirect, and holds a redirect that arrives during a stall until the stall releases.
- Sits between the branch/jump target calculators and the IF stage / instruction memory address port.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_W, 32, PC and target width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard-unit stall; PC holds while high.
- br_valid  in  1  branch resolution valid in EX this cycle.
- br_taken  in  1  branch outcome; qualified by br_valid.
- br_target  in  PC_W  branch target address (BTA).
- j_valid  in  1  jump decoded in ID this cycle.
- j_target  in  PC_W  jump target address.
- pc  out  PC_W  current fetch address (registered).
- pc_plus_4  out  PC_W  pc + 4, combinational, modulo 2^32.
- flush_if  out  1  kill the instruction in IF/ID this cycle.
- flush_id  out  1  kill the instruction in ID/EX this cycle.
- redirect_pending  out  1  a redirect is held waiting for stall to drop.
- align_err  out  1  sticky; target with bits [1:0] != 0 was accepted.

Behaviour:
- Reset (async, while reset_n=0):
  - pc=RESET_PC; state=RUN; pending target=0.
  - flush_if=0, flush_id=0, redirect_pending=0, align_err=0.
- Redirect event: br_evt = br_valid & br_taken; j_evt = j_valid.
  - Priority br_evt > j_evt, because the branch is the older instruction. A jump in the same cycle as a taken branch is wrong-path and is dropped.
- Accepted target has bits [1:0] forced to 00. If the original bits [1:0] != 0, set align_err (cleared only by reset).
- State RUN, stall=0:
  - br_evt: pc<=br_target, flush_if=1, flush_id=1.
  - else j_evt: pc<=j_target, flush_if=1, flush_id=0.
  - else pc<=pc+4 (wraps FFFF_FFFC to 0000_0000).
- State RUN, stall=1:
  - pc holds.
  - On br_evt or j_evt: latch the selected target and kind, go to HOLD. No flush this cycle.
- State HOLD (redirect_pending=1):
  - stall=1: pc holds.
    - A new br_evt replaces a held jump, or a held branch (a younger branch after an older one cannot occur; take the new one).
    - A new j_evt is ignored (wrong path).
  - stall=0:
    - pc<=held target (or a same-cycle br_evt target, which wins).
    - Assert flushes per the held kind, then go to RUN.
- Flush strobes are combinational, high only in the cycle the redirect is written into pc; one cycle wide.
- Latency: redirect visible on pc one clock after the event, or one clock after stall falls.
- reset_n asserted mid-HOLD: pending target discarded, pc=RESET_PC.

Optional Feature:
- Macro BRANCH_DELAY_SLOT_EN.
- Defined: MIPS delay-slot semantics.
  - Taken branch: flush_if=1, flush_id=0 (ID instruction is the delay slot).
  - Jump: no flush (IF instruction is the delay slot).
- Undefined: flush rules as in Behaviour.

Decomposition:
- Shared package cpu_pkg holds:
  - RESET_PC default.
  - State enum {RUN, HOLD}.
  - Redirect kind enum {RD_BRANCH, RD_JUMP}.
  - Constant PC_INC=4.
- One natural sub-module, redirect_hold: stores the pending target and kind, and implements the replace/ignore rules.

Test Plan:
- Reset release, no events, 4 cycles -> pc = 0, 4, 8, C; no flushes.
- At pc=0x10: br_valid=1, br_taken=1, br_target=0x40 -> next pc=0x40; flush_if=flush_id=1 for exactly that cycle.
- Same cycle: br_evt to 0x80 and j_valid to 0x200 -> pc=0x80; jump dropped.
- stall=1, j_valid with j_target=0x100, hold stall 3 cycles -> pc frozen, redirect_pending=1; stall falls -> pc=0x100, flush_if=1.
- In HOLD with a held jump to 0x100, br_evt to 0x300 -> after stall release pc=0x300, flush_if=flush_id=1.
- br_target=0x42 -> pc=0x40, align_err=1 stays set. Then reset_n pulse mid-HOLD -> pc=RESET_PC, redirect_pending=0, align_err=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the PC redirect logic.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_INC           = 4;

    typedef enum logic {RUN, HOLD} state_e;
    typedef enum logic {RD_BRANCH, RD_JUMP} rd_kind_e;

endpackage

// File: rtl/redirect_hold.sv
// Holds a redirect that arrives during a stall. A new taken branch replaces
// whatever is held; a jump is latched only when nothing is held yet.
module redirect_hold
    import cpu_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            br_evt_i,
    input  logic            j_evt_i,
    input  logic [PC_W-1:0] br_target_i,
    input  logic [PC_W-1:0] j_target_i,
    output logic            pending_o,
    output logic [PC_W-1:0] target_o,
    output rd_kind_e        kind_o
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] target_q, target_d;
    rd_kind_e        kind_q, kind_d;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        kind_d   = kind_q;
        if (stall_i) begin
            if (br_evt_i) begin
                state_d  = HOLD;
                target_d = {br_target_i[PC_W-1:2], 2'b00};
                kind_d   = RD_BRANCH;
            end else if (j_evt_i && (state_q == RUN)) begin
                state_d  = HOLD;
                target_d = {j_target_i[PC_W-1:2], 2'b00};
                kind_d   = RD_JUMP;
            end
        end else begin
            // The top consumes the held target in this same cycle.
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            target_q <= '0;
            kind_q   <= RD_BRANCH;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            kind_q   <= kind_d;
        end
    end

    assign pending_o = (state_q == HOLD);
    assign target_o  = target_q;
    assign kind_o    = kind_q;

endmodule

// File: rtl/pc_redirect_controller.sv
// Program counter with branch/jump redirect, stall hold and flush strobes.
// Optional macro BRANCH_DELAY_SLOT_EN selects MIPS delay-slot flush rules.
module pc_redirect_controller
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          PC_W     = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            br_valid,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            j_valid,
    input  logic [PC_W-1:0] j_target,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus_4,
    output logic            flush_if,
    output logic            flush_id,
    output logic            redirect_pending,
    output logic            align_err
);

    logic [PC_W-1:0] pc_q;
    logic            align_err_q;
    logic            br_evt, j_take, new_evt, redirect_now, wr_is_br;
    logic [PC_W-1:0] new_target, wr_target, held_target;
    rd_kind_e        held_kind;

    redirect_hold #(.PC_W(PC_W)) u_hold (
        .clk         (clk),
        .rst_n       (reset_n),
        .stall_i     (stall),
        .br_evt_i    (br_evt),
        .j_evt_i     (j_valid),
        .br_target_i (br_target),
        .j_target_i  (j_target),
        .pending_o   (redirect_pending),
        .target_o    (held_target),
        .kind_o      (held_kind)
    );

    // A jump alongside a taken branch, or while a redirect is held, is wrong-path.
    assign br_evt       = br_valid & br_taken;
    assign j_take       = j_valid & ~br_evt & ~redirect_pending;
    assign new_evt      = br_evt | j_take;
    assign new_target   = br_evt ? br_target : j_target;
    assign redirect_now = ~stall & (new_evt | redirect_pending);
    assign wr_target    = new_evt ? {new_target[PC_W-1:2], 2'b00} : held_target;
    assign wr_is_br     = new_evt ? br_evt : (held_kind == RD_BRANCH);

    always_comb begin
        flush_if = 1'b0;
        flush_id = 1'b0;
        if (redirect_now) begin
`ifdef BRANCH_DELAY_SLOT_EN
            flush_if = wr_is_br;
            flush_id = 1'b0;
`else
            flush_if = 1'b1;
            flush_id = wr_is_br;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q        <= RESET_PC[PC_W-1:0];
            align_err_q <= 1'b0;
        end else begin
            if (!stall)
                pc_q <= redirect_now ? wr_target : pc_plus_4;
            if (new_evt && (new_target[1:0] != 2'b00))
                align_err_q <= 1'b1;
        end
    end

    assign pc        = pc_q;
    assign pc_plus_4 = pc_q + PC_W'(PC_INC);
    assign align_err = align_err_q;

endmodule

// File: tb/tb_pc_redirect_controller.sv
// Randomized plus directed bench for pc_redirect_controller against a
// cycle-level model of the redirect rules.
module tb_pc_redirect_controller;

    logic        clk = 1'b0;
    logic        reset_n, stall, br_valid, br_taken, j_valid;
    logic [31:0] br_target, j_target;
    logic [31:0] pc, pc_plus_4;
    logic        flush_if, flush_id, redirect_pending, align_err;

    pc_redirect_controller dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .stall            (stall),
        .br_valid         (br_valid),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .j_valid          (j_valid),
        .j_target         (j_target),
        .pc               (pc),
        .pc_plus_4        (pc_plus_4),
        .flush_if         (flush_if),
        .flush_id         (flush_id),
        .redirect_pending (redirect_pending),
        .align_err        (align_err)
    );

    always #5 clk = ~clk;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit BR_FIF = 1'b1, BR_FID = 1'b0, J_FIF = 1'b0;
`else
    localparam bit BR_FIF = 1'b1, BR_FID = 1'b1, J_FIF = 1'b1;
`endif

    int n_vec = 0;
    int n_bad = 0;

    // Model state: architectural pc, an optional held redirect, sticky error.
    logic [31:0] m_pc, m_pend_tgt;
    bit          m_pend, m_pend_br, m_align;
    logic        s_fif, s_fid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] al(input logic [31:0] t);
        return t & ~32'h3;
    endfunction

    task automatic cycle(input bit st, input bit bv, input bit bt, input logic [31:0] bta,
                         input bit jv, input logic [31:0] jta);
        bit          br, redir, rbr, e_fif, e_fid;
        logic [31:0] rt;
        @(negedge clk);
        stall = st; br_valid = bv; br_taken = bt; br_target = bta;
        j_valid = jv; j_target = jta;
        #1;
        br = bv & bt; redir = 1'b0; rbr = 1'b0; rt = '0;
        if (!st) begin
            if (br) begin redir = 1'b1; rbr = 1'b1; rt = al(bta); end
            else if (m_pend) begin redir = 1'b1; rbr = m_pend_br; rt = m_pend_tgt; end
            else if (jv) begin redir = 1'b1; rbr = 1'b0; rt = al(jta); end
        end
`ifdef BRANCH_DELAY_SLOT_EN
        e_fif = redir & rbr;
        e_fid = 1'b0;
`else
        e_fif = redir;
        e_fid = redir & rbr;
`endif
        check("pc", pc, m_pc);
        check("pc_plus_4", pc_plus_4, m_pc + 32'd4);
        check("flush_if", 32'(flush_if), 32'(e_fif));
        check("flush_id", 32'(flush_id), 32'(e_fid));
        check("redirect_pending", 32'(redirect_pending), 32'(m_pend));
        check("align_err", 32'(align_err), 32'(m_align));
        s_fif = flush_if; s_fid = flush_id;
        $display("cyc t=%0t st=%0d br=%0d/%0d:%h j=%0d:%h pc=%h fl=%0d%0d pend=%0d aerr=%0d",
                 $time, st, bv, bt, bta, jv, jta, pc, flush_if, flush_id, redirect_pending, align_err);
        if (br) m_align |= (bta[1:0] != 2'b00);
        else if (jv && !m_pend) m_align |= (jta[1:0] != 2'b00);
        if (!st) begin
            m_pc   = redir ? rt : m_pc + 32'd4;
            m_pend = 1'b0;
        end else if (br) begin
            m_pend = 1'b1; m_pend_tgt = al(bta); m_pend_br = 1'b1;
        end else if (jv && !m_pend) begin
            m_pend = 1'b1; m_pend_tgt = al(jta); m_pend_br = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; stall = 1'b0; br_valid = 1'b0; br_taken = 1'b0;
        j_valid = 1'b0; br_target = '0; j_target = '0;
        #1;
        m_pc = 32'h0; m_pend = 1'b0; m_pend_tgt = '0; m_pend_br = 1'b0; m_align = 1'b0;
        check("rst_pc", pc, 32'h0);
        check("rst_pending", 32'(redirect_pending), 32'h0);
        check("rst_align", 32'(align_err), 32'h0);
        check("rst_flush", {30'b0, flush_if, flush_id}, 32'h0);
        $display("reset t=%0t pc=%h", $time, pc);
        @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_tgt();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(99) < 3) t = 32'hFFFF_FFFC;
        else if ($urandom_range(99) < 85) t = al(t);
        return t;
    endfunction

    initial begin
        reset_n = 1'b1;
        do_reset();

        // Sequential fetch from reset.
        idle(); check("seq0", pc, 32'h4);
        idle(); check("seq1", pc, 32'h8);
        idle(); check("seq2", pc, 32'hC);
        idle(); check("seq3", pc, 32'h10);

        // Taken branch at 0x10.
        cycle(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
        check("br_pc", pc, 32'h40);
        check("br_flush", {30'b0, s_fif, s_fid}, {30'b0, BR_FIF, BR_FID});
        idle();
        check("br_flush_gone", {30'b0, s_fif, s_fid}, 32'h0);

        // Branch and jump together: jump dropped.
        cycle(1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h200);
        check("br_beats_j", pc, 32'h80);

        // Jump during a 3-cycle stall.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("stall_pc", pc, 32'h80);
        check("stall_pend", 32'(redirect_pending), 32'h1);
        idle();
        check("held_j_pc", pc, 32'h100);
        check("held_j_flush", {30'b0, s_fif, s_fid}, {30'b0, J_FIF, 1'b0});

        // Held jump replaced by a branch.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100);
        cycle(1'b1, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
        idle();
        check("replace_pc", pc, 32'h300);
        check("replace_flush", {30'b0, s_fif, s_fid}, {30'b0, BR_FIF, BR_FID});

        // Wrap at the top of the address space.
        cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        idle();
        check("wrap_pc", pc, 32'h0);

        // Misaligned target, sticky error, then reset mid-HOLD.
        cycle(1'b0, 1'b1, 1'b1, 32'h42, 1'b0, 32'h0);
        check("mis_pc", pc, 32'h40);
        idle();
        check("mis_sticky", 32'(align_err), 32'h1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h500);
        check("hold_before_rst", 32'(redirect_pending), 32'h1);
        do_reset();
        idle();
        check("post_rst_pc", pc, 32'h4);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(99) < 2) begin
                do_reset();
            end else begin
                cycle($urandom_range(99) < 40, $urandom_range(99) < 25, $urandom_range(1) == 1,
                      rand_tgt(), $urandom_range(99) < 25, rand_tgt());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
